// File: rtl/chunked_adder_seq_pkg.sv
// Shared constants for chunk-serial adder controllers built around the
// 9-bit square_root_adder.
package chunked_adder_seq_pkg;

    localparam int CHUNK_W = 9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ADD  = ST_ADD,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/chunked_adder_seq_sqrt_adder.sv
// 9-bit carry-select ("square-root") adder: three 3-bit blocks, and the upper
// two blocks are precomputed for both incoming carries.
module square_root_adder
    import chunked_adder_seq_pkg::*;
(
    output logic [CHUNK_W-1:0] sum,
    output logic               c_out,
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               c_in
);

    logic [3:0] blk0;
    logic [3:0] blk1C0;
    logic [3:0] blk1C1;
    logic [3:0] blk2C0;
    logic [3:0] blk2C1;
    logic       carry1;
    logic       carry2;

    // Each upper block's select is the real carry out of the block below it.
    always_comb begin
        blk0   = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, c_in};
        blk1C0 = {1'b0, a[5:3]} + {1'b0, b[5:3]};
        blk1C1 = blk1C0 + 4'd1;
        blk2C0 = {1'b0, a[8:6]} + {1'b0, b[8:6]};
        blk2C1 = blk2C0 + 4'd1;

        carry1   = blk0[3];
        sum[2:0] = blk0[2:0];
        {carry2, sum[5:3]} = carry1 ? blk1C1 : blk1C0;
        {c_out,  sum[8:6]} = carry2 ? blk2C1 : blk2C0;
    end

endmodule

// File: rtl/chunked_adder_seq.sv
// Adds two CHUNKS*9-bit operands by running one shared square_root_adder over
// the operands one 9-bit chunk per cycle, LSB chunk first.
module chunked_adder_seq
    import chunked_adder_seq_pkg::*;
#(
    parameter int CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHUNK_W*CHUNKS-1:0] a,
    input  logic [CHUNK_W*CHUNKS-1:0] b,
    input  logic                      c_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHUNK_W*CHUNKS-1:0] sum,
    output logic                      c_out
);

    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    state_e                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic                             carry_q, carry_d;
    logic                             cOut_q, cOut_d;
    logic [CHUNKS-1:0][CHUNK_W-1:0]   opA_q, opA_d;
    logic [CHUNKS-1:0][CHUNK_W-1:0]   opB_q, opB_d;
    logic [CHUNKS-1:0][CHUNK_W-1:0]   sum_q, sum_d;

    logic [CHUNK_W-1:0]               addSum;
    logic                             addCout;

    square_root_adder u_adder (
        .sum   (addSum),
        .c_out (addCout),
        .a     (opA_q[idx_q]),
        .b     (opB_q[idx_q]),
        .c_in  (carry_q)
    );

    // Operands are captured at acceptance so the requester may change a/b
    // freely while the chunks are still being worked through.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cOut_d  = cOut_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        sum_d   = sum_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opA_d   = a;
                    opB_d   = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[idx_q] = addSum;
                carry_d      = addCout;
                if (idx_q == LAST_IDX) begin
                    cOut_d  = addCout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cOut_q  <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cOut_q  <= cOut_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = cOut_q;

endmodule
